// File: rtl/rd_arb_if.sv
// Command/data bus between the read arbiter and the DDR read controller.
interface rd_arb_if #(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int MEM_DQ_WIDTH    = 16
);
  logic [CTRL_ADDR_WIDTH-1:0] read_addr;
  logic [3:0]                 read_id;
  logic [3:0]                 read_len;
  logic                       read_en;
  logic                       read_ready;
  logic                       read_done_p;
  logic [MEM_DQ_WIDTH*8-1:0]  read_rdata;
  logic                       read_rdata_en;

  modport master (
    output read_addr, read_id, read_len, read_en, read_ready,
    input  read_done_p, read_rdata, read_rdata_en
  );
  modport slave (
    input  read_addr, read_id, read_len, read_en, read_ready,
    output read_done_p, read_rdata, read_rdata_en
  );
endinterface

// File: rtl/rd_arb.sv
// Round-robin read arbiter: three requesters share one DDR read controller,
// with per-transaction beat accounting and a sticky beat-mismatch flag.
module rd_arb #(
  parameter int CTRL_ADDR_WIDTH = 28,
  parameter int MEM_DQ_WIDTH    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2:0]                   req_valid,
  input  logic [3*CTRL_ADDR_WIDTH-1:0] req_addr,
  input  logic [11:0]                  req_len,
  output logic [2:0]                   req_ack,
  output logic [MEM_DQ_WIDTH*8-1:0]    req_rdata,
  output logic [2:0]                   req_rdata_en,
  output logic [2:0]                   req_done,
  output logic                         busy,
  output logic                         err_beat,
  rd_arb_if.master                     rd
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t     state, state_nxt;
  logic [1:0] owner, last_grant, grant;
  logic       grant_vld;
  logic [4:0] beat_cnt, beat_cnt_nxt, beat_exp;
  logic       beat_ok;

  assign beat_exp     = {1'b0, rd.read_len} + 5'd1;
  assign beat_ok      = (state == WAIT) && rd.read_rdata_en && (beat_cnt < beat_exp);
  assign beat_cnt_nxt = beat_cnt + {4'd0, beat_ok};

  // Search starts just after the previous owner so every requester gets a turn.
  always_comb begin
    int         i_rr;
    logic [1:0] idx;
    grant     = 2'd0;
    grant_vld = 1'b0;
    i_rr      = 0;
    idx       = 2'd0;
    for (int k = 0; k < 3; k++) begin
      i_rr = (int'(last_grant) + 1 + k) % 3;
      idx  = i_rr[1:0];
      if (!grant_vld && req_valid[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    busy          = (state != IDLE);
    rd.read_en    = (state == ISSUE);
    rd.read_ready = 1'b1;
    case (state)
      IDLE:    if (grant_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (rd.read_done_p) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_rdata = rd.read_rdata;

  // Data-valid goes only to the current owner; excess beats are swallowed.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_den
      assign req_rdata_en[gi] = beat_ok && (owner == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner        <= 2'd0;
      last_grant   <= 2'd2;
      beat_cnt     <= 5'd0;
      req_ack      <= 3'd0;
      req_done     <= 3'd0;
      err_beat     <= 1'b0;
      rd.read_addr <= '0;
      rd.read_id   <= 4'd0;
      rd.read_len  <= 4'd0;
    end else begin
      req_ack  <= 3'd0;
      req_done <= 3'd0;
      case (state)
        IDLE: if (grant_vld) begin
          owner        <= grant;
          rd.read_addr <= req_addr[32'(grant)*CTRL_ADDR_WIDTH +: CTRL_ADDR_WIDTH];
          rd.read_len  <= req_len[32'(grant)*4 +: 4];
          rd.read_id   <= {2'b00, grant};
          req_ack      <= 3'b001 << grant;
        end
        ISSUE: beat_cnt <= 5'd0;
        WAIT: begin
          beat_cnt <= beat_cnt_nxt;
          if (rd.read_done_p) begin
            req_done   <= 3'b001 << owner;
            last_grant <= owner;
          end
        end
        default: ;
      endcase
      // A coincident last beat is already in beat_cnt_nxt, so it is not short.
      if ((rd.read_rdata_en && !beat_ok) ||
          ((state == WAIT) && rd.read_done_p && (beat_cnt_nxt < beat_exp)))
        err_beat <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rd_arb.sv
// Bench for rd_arb: vector table, hand-written corner sequences, and random
// transactions checked against a round-robin/beat-count reference model.
module tb_rd_arb;
  localparam int AW = 28;
  localparam int DQ = 16;
  localparam int DW = DQ * 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    req_valid;
  logic [3*AW-1:0] req_addr;
  logic [11:0]   req_len;
  logic [2:0]    req_ack, req_rdata_en, req_done;
  logic [DW-1:0] req_rdata;
  logic          busy, err_beat;

  always #5 clk = ~clk;

  rd_arb_if #(.CTRL_ADDR_WIDTH(AW), .MEM_DQ_WIDTH(DQ)) rd ();

  rd_arb #(.CTRL_ADDR_WIDTH(AW), .MEM_DQ_WIDTH(DQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_len(req_len), .req_ack(req_ack), .req_rdata(req_rdata),
    .req_rdata_en(req_rdata_en), .req_done(req_done), .busy(busy),
    .err_beat(err_beat), .rd(rd)
  );

  int checks = 0, errors = 0;
  int ack_cnt[3], done_cnt[3], en_cnt[3];
  int rd_en_cnt, cyc = 0, done_p_cyc = -100, done_seen_cyc, rd_en_cyc;
  logic [AW-1:0] cap_addr;
  logic [3:0]    cap_len, cap_id;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 3; i++) begin ack_cnt[i] = 0; done_cnt[i] = 0; en_cnt[i] = 0; end
    rd_en_cnt = 0; done_seen_cyc = -100; rd_en_cyc = -100;
  endtask

  // Sample on the falling edge, then step to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (req_ack[i])      ack_cnt[i]++;
      if (req_done[i])     done_cnt[i]++;
      if (req_rdata_en[i]) en_cnt[i]++;
    end
    if (rd.read_en) begin
      rd_en_cnt++; rd_en_cyc = cyc;
      cap_addr = rd.read_addr; cap_len = rd.read_len; cap_id = rd.read_id;
    end
    if (rd.read_done_p) done_p_cyc = cyc;
    if (|req_done) done_seen_cyc = cyc;
    if (rd.read_rdata_en) chk("rdata_passthru", 64'(req_rdata === rd.read_rdata), 64'd1);
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic wait_read_en();
    for (int n = 0; n < 8 && rd_en_cnt == 0; n++) tick();
    chk("read_en_seen", 64'(rd_en_cnt != 0), 64'd1);
  endtask

  // Plays the read controller: nbeats data beats, then (or with the last beat) done.
  task automatic run_txn(input logic [2:0] valid, input logic [3*AW-1:0] addr,
                         input logic [11:0] len, input bit keep, input int nbeats,
                         input bit coincide);
    clr();
    req_valid = valid; req_addr = addr; req_len = len;
    tick();
    if (!keep) req_valid = 3'd0;
    wait_read_en();
    for (int b = 0; b < nbeats; b++) begin
      rd.read_rdata    = {$urandom, $urandom, $urandom, $urandom};
      rd.read_rdata_en = 1'b1;
      rd.read_done_p   = coincide && (b == nbeats - 1);
      tick();
    end
    rd.read_rdata_en = 1'b0;
    if (!coincide || nbeats == 0) begin rd.read_done_p = 1'b1; tick(); end
    rd.read_done_p = 1'b0;
    tick();
  endtask

  task automatic check_txn(input int own, input logic [3*AW-1:0] addr,
                           input logic [11:0] len, input int nbeats, input bit exp_err);
    int elen, routed;
    elen   = int'(len[own*4 +: 4]);
    routed = (nbeats < elen + 1) ? nbeats : elen + 1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("req_ack[%0d] pulses", i), 64'(ack_cnt[i]), 64'(i == own));
      chk($sformatf("req_rdata_en[%0d] beats", i), 64'(en_cnt[i]), 64'(i == own ? routed : 0));
      chk($sformatf("req_done[%0d] pulses", i), 64'(done_cnt[i]), 64'(i == own));
    end
    chk("read_en cycles", 64'(rd_en_cnt), 64'd1);
    chk("read_addr", 64'(cap_addr), 64'(addr[own*AW +: AW]));
    chk("read_len", 64'(cap_len), 64'(elen));
    chk("read_id", 64'(cap_id), 64'(own));
    chk("done latency", 64'(done_seen_cyc - done_p_cyc), 64'd1);
    chk("err_beat", 64'(err_beat), 64'(exp_err));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
  endtask

  typedef struct {
    logic [2:0]      valid;
    logic [3*AW-1:0] addr;
    logic [11:0]     len;
    bit              keep;
    int              nbeats;
    bit              coincide;
    int              owner;
    bit              err;
    bit              lat2;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    logic [3*AW-1:0] A;
    int prev_done, last, own, elen, nb, r, start_done;
    bit merr, coin;
    logic [2:0] v;
    logic [3*AW-1:0] ra;
    logic [11:0] rl;

    A = {28'h0C00300, 28'h0001000, 28'h0A00010};
    vt[0] = '{3'b111, A, {4'd1, 4'd7, 4'd2}, 1, 3, 0, 0, 0, 0};
    vt[1] = '{3'b111, A, {4'd1, 4'd7, 4'd2}, 1, 8, 1, 1, 0, 1};
    vt[2] = '{3'b111, A, {4'd1, 4'd7, 4'd2}, 0, 2, 0, 2, 0, 1};
    vt[3] = '{3'b010, A, {4'd1, 4'd7, 4'd2}, 0, 8, 0, 1, 0, 0};
    vt[4] = '{3'b001, A, {4'd1, 4'd7, 4'd0}, 1, 1, 1, 0, 0, 0};
    vt[5] = '{3'b001, A, {4'd1, 4'd7, 4'd0}, 0, 1, 1, 0, 0, 1};
    vt[6] = '{3'b001, A, {4'd3, 4'd7, 4'd3}, 0, 5, 0, 0, 1, 0};
    vt[7] = '{3'b100, A, {4'd3, 4'd7, 4'd3}, 0, 2, 0, 2, 1, 0};

    req_valid = 3'd0; req_addr = '0; req_len = '0;
    rd.read_done_p = 1'b0; rd.read_rdata = '0; rd.read_rdata_en = 1'b0;
    clr();
    tick(); tick();
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset read_en", 64'(rd.read_en), 64'd0);
    chk("reset req_ack", 64'(req_ack), 64'd0);
    chk("reset req_done", 64'(req_done), 64'd0);
    chk("reset err_beat", 64'(err_beat), 64'd0);
    chk("reset read_addr", 64'(rd.read_addr), 64'd0);
    chk("reset read_id", 64'(rd.read_id), 64'd0);
    chk("reset read_len", 64'(rd.read_len), 64'd0);
    chk("read_ready", 64'(rd.read_ready), 64'd1);
    rst_n = 1'b1; tick();

    foreach (vt[k]) begin
      prev_done = done_p_cyc;
      run_txn(vt[k].valid, vt[k].addr, vt[k].len, vt[k].keep, vt[k].nbeats, vt[k].coincide);
      check_txn(vt[k].owner, vt[k].addr, vt[k].len, vt[k].nbeats, vt[k].err);
      if (vt[k].lat2) chk($sformatf("vec%0d done->read_en gap", k), 64'(rd_en_cyc - prev_done), 64'd2);
    end

    // Owner 0 completes, so only a reset can put requester 0 first again.
    run_txn(3'b001, A, {4'd1, 4'd7, 4'd2}, 0, 3, 0);
    check_txn(0, A, {4'd1, 4'd7, 4'd2}, 3, 1);
    clr();
    start_done = done_p_cyc;
    req_valid = 3'b010; tick(); req_valid = 3'd0;
    wait_read_en();
    for (int b = 0; b < 3; b++) begin rd.read_rdata_en = 1'b1; tick(); end
    rd.read_rdata_en = 1'b0;
    rst_n = 1'b0; #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort read_en", 64'(rd.read_en), 64'd0);
    chk("abort err_beat", 64'(err_beat), 64'd0);
    tick(); tick(); rst_n = 1'b1; tick(); tick();
    chk("abort req_done", 64'(done_cnt[0] + done_cnt[1] + done_cnt[2]), 64'd0);
    chk("abort no done_p", 64'(done_p_cyc), 64'(start_done));
    run_txn(3'b111, A, {4'd1, 4'd7, 4'd2}, 0, 3, 0);
    check_txn(0, A, {4'd1, 4'd7, 4'd2}, 3, 0);

    // Stray beat while idle.
    clr();
    rd.read_rdata_en = 1'b1; tick(); rd.read_rdata_en = 1'b0; tick();
    chk("idle beat routed", 64'(en_cnt[0] + en_cnt[1] + en_cnt[2]), 64'd0);
    chk("idle beat err_beat", 64'(err_beat), 64'd1);

    do_reset();
    last = 2; merr = 1'b0;
    for (int t = 0; t < 40; t++) begin
      v  = 3'($urandom_range(1, 7));
      ra = {28'($urandom), 28'($urandom), 28'($urandom)};
      rl = 12'($urandom);
      own = -1;
      for (int k = 1; k <= 3; k++)
        if (own < 0 && v[(last + k) % 3]) own = (last + k) % 3;
      elen = int'(rl[own*4 +: 4]);
      r = $urandom_range(0, 3);
      if (r == 2)      nb = $urandom_range(0, elen);
      else if (r == 3) nb = elen + 1 + $urandom_range(1, 2);
      else             nb = elen + 1;
      coin = 1'($urandom_range(0, 1));
      if (nb != elen + 1) merr = 1'b1;
      run_txn(v, ra, rl, 0, nb, coin);
      check_txn(own, ra, rl, nb, merr);
      last = own;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
